// File: rtl/sram_responder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_responder_pkg: SRAM widths shared with the BIST and SRAM controller.
// rev 1.0
// ---------------------------------------------------------------------------
package sram_responder_pkg;

  localparam int SRAM_ADDR_WIDTH   = 18;
  localparam int SRAM_DATA_WIDTH   = 16;
  localparam int SRAM_READ_LATENCY = 2;
  localparam int FAULT_BIT_WIDTH   = 4;

  typedef logic [SRAM_ADDR_WIDTH-1:0] addr_t;
  typedef logic [SRAM_DATA_WIDTH-1:0] data_t;

  localparam addr_t COUNT_MAX = {SRAM_ADDR_WIDTH{1'b1}};

  // One buffered request: fault settings travel with the request they were sampled with.
  typedef struct packed {
    logic                       vld;
    logic                       we_n;
    addr_t                      addr;
    data_t                      wdata;
    logic                       f_en;
    addr_t                      f_addr;
    logic [FAULT_BIT_WIDTH-1:0] f_bit;
    logic                       f_val;
  } req_t;

  localparam req_t REQ_IDLE = '{
    vld:    1'b0,
    we_n:   1'b1,
    addr:   '0,
    wdata:  '0,
    f_en:   1'b0,
    f_addr: '0,
    f_bit:  '0,
    f_val:  1'b0
  };

  function automatic addr_t sat_inc(input addr_t v);
    return (v == COUNT_MAX) ? v : v + addr_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_responder_storage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_responder_storage: word array with per-word valid bitmap, 1W/1R port,
// registered read data. rev 1.0
// ---------------------------------------------------------------------------
module sram_responder_storage
  import sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [DEPTH_LOG2-1:0] i_wr_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [DEPTH_LOG2-1:0] i_rd_addr,
  output logic [SRAM_DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  data_t            mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  data_t            rd_data_q;
  data_t            rd_data_d;

  always_comb begin
    valid_d = valid_q;
    if (i_wr_en) begin
      valid_d[i_wr_addr] = 1'b1;
    end
    rd_data_d = i_rd_en ? mem_q[i_rd_addr] : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      rd_data_q <= '0;
    end else begin
      valid_q   <= valid_d;
      rd_data_q <= rd_data_d;
    end
  end

  // The array itself is never reset; the valid bits carry the "written" state.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = valid_q[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_responder: two-stage SRAM model with stuck-at fault injection,
// saturating request counters and an uninitialised-read flag. rev 1.0
// ---------------------------------------------------------------------------
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  input  logic [SRAM_ADDR_WIDTH-1:0] SRAM_address,
  input  logic [SRAM_DATA_WIDTH-1:0] SRAM_write_data,
  input  logic                       SRAM_we_n,
  output logic [SRAM_DATA_WIDTH-1:0] SRAM_read_data,
  input  logic                       Fault_enable,
  input  logic [SRAM_ADDR_WIDTH-1:0] Fault_address,
  input  logic [FAULT_BIT_WIDTH-1:0] Fault_bit,
  input  logic                       Fault_value,
  output logic [SRAM_ADDR_WIDTH-1:0] Write_count,
  output logic [SRAM_ADDR_WIDTH-1:0] Read_count,
  output logic                       Uninit_read
);

  req_t  s1_q, s1_d;
  req_t  s2_q, s2_d;
  addr_t write_count_q, write_count_d;
  addr_t read_count_q, read_count_d;
  logic  uninit_q, uninit_d;
  data_t fault_mask_q, fault_mask_d;
  data_t fault_set_q, fault_set_d;

  logic  wr_en;
  logic  rd_en;
  logic  rd_valid;
  logic  fault_hit;
  data_t fault_onehot;
  data_t store_rd_data;

  // s1 captures the request at edge k, s2 holds it from edge k+1, and the
  // access completes at edge k+2.
  always_comb begin
    s1_d = '{
      vld:    1'b1,
      we_n:   SRAM_we_n,
      addr:   SRAM_address,
      wdata:  SRAM_write_data,
      f_en:   Fault_enable,
      f_addr: Fault_address,
      f_bit:  Fault_bit,
      f_val:  Fault_value
    };
    s2_d = s1_q;

    wr_en        = s2_q.vld & ~s2_q.we_n;
    rd_en        = s2_q.vld &  s2_q.we_n;
    fault_hit    = s2_q.f_en && (s2_q.addr == s2_q.f_addr);
    fault_onehot = data_t'(1) << s2_q.f_bit;

    // Fault masks are latched alongside the read data so they hold with it.
    fault_mask_d = fault_mask_q;
    fault_set_d  = fault_set_q;
    if (rd_en) begin
      fault_mask_d = fault_hit ? fault_onehot : '0;
      fault_set_d  = (fault_hit && s2_q.f_val) ? fault_onehot : '0;
    end

    write_count_d = wr_en ? sat_inc(write_count_q) : write_count_q;
    read_count_d  = rd_en ? sat_inc(read_count_q)  : read_count_q;
    uninit_d      = uninit_q | (rd_en & ~rd_valid);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      s1_q          <= REQ_IDLE;
      s2_q          <= REQ_IDLE;
      write_count_q <= '0;
      read_count_q  <= '0;
      uninit_q      <= 1'b0;
      fault_mask_q  <= '0;
      fault_set_q   <= '0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      write_count_q <= write_count_d;
      read_count_q  <= read_count_d;
      uninit_q      <= uninit_d;
      fault_mask_q  <= fault_mask_d;
      fault_set_q   <= fault_set_d;
    end
  end

  sram_responder_storage #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_storage (
    .clk        (Clock),
    .rst_n      (Resetn),
    .i_wr_en    (wr_en),
    .i_wr_addr  (s2_q.addr[DEPTH_LOG2-1:0]),
    .i_wr_data  (s2_q.wdata),
    .i_rd_en    (rd_en),
    .i_rd_addr  (s2_q.addr[DEPTH_LOG2-1:0]),
    .o_rd_data  (store_rd_data),
    .o_rd_valid (rd_valid)
  );

  assign SRAM_read_data = (store_rd_data & ~fault_mask_q) | fault_set_q;
  assign Write_count    = write_count_q;
  assign Read_count     = read_count_q;
  assign Uninit_read    = uninit_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sram_responder: directed stimulus, behavioural reference model and
// per-cycle output comparison for sram_responder. rev 1.0
// ---------------------------------------------------------------------------
module tb_sram_responder;

  localparam int DEPTH = 256;

  logic        Clock;
  logic        Resetn;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic        Fault_enable;
  logic [17:0] Fault_address;
  logic [3:0]  Fault_bit;
  logic        Fault_value;
  logic [17:0] Write_count;
  logic [17:0] Read_count;
  logic        Uninit_read;

  int total = 0;
  int bad   = 0;
  bit preload;

  sram_responder #(
    .DEPTH_LOG2 (8)
  ) dut (
    .Clock           (Clock),
    .Resetn          (Resetn),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .SRAM_read_data  (SRAM_read_data),
    .Fault_enable    (Fault_enable),
    .Fault_address   (Fault_address),
    .Fault_bit       (Fault_bit),
    .Fault_value     (Fault_value),
    .Write_count     (Write_count),
    .Read_count      (Read_count),
    .Uninit_read     (Uninit_read)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // ------------------------- reference model -------------------------------
  typedef struct packed {
    bit          v;
    bit          we_n;
    logic [17:0] a;
    logic [15:0] d;
    bit          fen;
    logic [17:0] fa;
    logic [3:0]  fb;
    bit          fv;
  } mreq_t;

  logic [15:0] m_mem [DEPTH];
  bit          m_val [DEPTH];
  mreq_t       p0, p1;
  logic [17:0] m_w, m_r;
  bit          m_un;
  logic [15:0] m_rd;
  bit          m_rd_known;
  int          m_idx;

  function automatic logic [17:0] sat18(input logic [17:0] v);
    return (v == 18'h3FFFF) ? v : v + 18'd1;
  endfunction

  // A request seen at edge j takes effect on the outputs at edge j+2.
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      p0 = '0;
      p1 = '0;
      m_w = '0;
      m_r = '0;
      m_un = 1'b0;
      m_rd = '0;
      m_rd_known = 1'b1;
      for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
    end else begin
      if (p1.v) begin
        m_idx = int'(p1.a) % DEPTH;
        if (!p1.we_n) begin
          m_mem[m_idx] = p1.d;
          m_val[m_idx] = 1'b1;
          m_w = sat18(m_w);
        end else begin
          m_r = sat18(m_r);
          if (!m_val[m_idx]) begin
            m_un = 1'b1;
            m_rd_known = 1'b0;
          end else begin
            m_rd = m_mem[m_idx];
            if (p1.fen && (p1.a == p1.fa)) m_rd[p1.fb] = p1.fv;
            m_rd_known = 1'b1;
          end
        end
      end
      if (preload) m_w = 18'h3FFFF;
      p1 = p0;
      p0.v    = 1'b1;
      p0.we_n = SRAM_we_n;
      p0.a    = SRAM_address;
      p0.d    = SRAM_write_data;
      p0.fen  = Fault_enable;
      p0.fa   = Fault_address;
      p0.fb   = Fault_bit;
      p0.fv   = Fault_value;
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge Clock);
      if (m_rd_known) check("cyc_read_data", 32'(SRAM_read_data), 32'(m_rd));
      check("cyc_write_count", 32'(Write_count), 32'(m_w));
      check("cyc_read_count", 32'(Read_count), 32'(m_r));
      check("cyc_uninit", 32'(Uninit_read), 32'(m_un));
    end
  end

  // ------------------------- stimulus --------------------------------------
  task automatic issue(input bit wr, input logic [17:0] a, input logic [15:0] d);
    SRAM_we_n       = ~wr;
    SRAM_address    = a;
    SRAM_write_data = d;
    @(posedge Clock);
    #2;
  endtask

  task automatic do_reset();
    Resetn          = 1'b0;
    SRAM_we_n       = 1'b1;
    SRAM_address    = '0;
    SRAM_write_data = '0;
    @(posedge Clock);
    #2;
    check("rst_read_data", 32'(SRAM_read_data), 32'h0);
    check("rst_write_count", 32'(Write_count), 32'h0);
    check("rst_read_count", 32'(Read_count), 32'h0);
    check("rst_uninit", 32'(Uninit_read), 32'h0);
    @(posedge Clock);
    #2;
    Resetn = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    preload       = 1'b0;
    Fault_enable  = 1'b0;
    Fault_address = '0;
    Fault_bit     = '0;
    Fault_value   = 1'b0;
    do_reset();

    // Write then read-back, two-edge latency.
    issue(1'b1, 18'd5, 16'hA5A5);
    issue(1'b0, 18'd5, 16'h0);
    issue(1'b0, 18'd5, 16'h0);
    check("lat_not_early", 32'(SRAM_read_data), 32'h0);
    issue(1'b0, 18'd5, 16'h0);
    check("rd_a5a5", 32'(SRAM_read_data), 32'hA5A5);
    check("wcount_one", 32'(Write_count), 32'd1);
    check("rcount_one", 32'(Read_count), 32'd1);
    check("uninit_clear", 32'(Uninit_read), 32'h0);

    // Uninitialised read flag is sticky.
    do_reset();
    issue(1'b0, 18'd7, 16'h0);
    issue(1'b1, 18'd7, 16'h0707);
    issue(1'b0, 18'd7, 16'h0);
    check("uninit_set", 32'(Uninit_read), 32'h1);
    issue(1'b0, 18'd7, 16'h0);
    issue(1'b0, 18'd7, 16'h0);
    check("rd_0707", 32'(SRAM_read_data), 32'h0707);
    check("uninit_sticky", 32'(Uninit_read), 32'h1);
    do_reset();

    // Fault injection, full-address match and per-request fault sampling.
    Fault_enable  = 1'b1;
    Fault_address = 18'd3;
    Fault_bit     = 4'd0;
    Fault_value   = 1'b1;
    issue(1'b1, 18'd3, 16'h0000);
    issue(1'b0, 18'd3, 16'h0);
    issue(1'b0, 18'h00103, 16'h0);
    Fault_enable = 1'b0;
    issue(1'b0, 18'd3, 16'h0);
    check("fault_hit", 32'(SRAM_read_data), 32'h0001);
    Fault_enable = 1'b1;
    issue(1'b0, 18'd3, 16'h0);
    check("fault_alias", 32'(SRAM_read_data), 32'h0000);
    Fault_enable = 1'b0;
    issue(1'b0, 18'd3, 16'h0);
    check("fault_disabled", 32'(SRAM_read_data), 32'h0000);
    issue(1'b0, 18'd3, 16'h0);
    check("fault_reenabled", 32'(SRAM_read_data), 32'h0001);
    Fault_bit   = 4'd15;
    Fault_value = 1'b0;
    issue(1'b1, 18'd3, 16'hFFFF);
    Fault_enable = 1'b1;
    issue(1'b0, 18'd3, 16'h0);
    Fault_enable = 1'b0;
    issue(1'b0, 18'd3, 16'h0);
    issue(1'b0, 18'd3, 16'h0);
    check("fault_stuck0", 32'(SRAM_read_data), 32'h7FFF);
    issue(1'b0, 18'd3, 16'h0);
    check("stored_intact", 32'(SRAM_read_data), 32'hFFFF);
    Fault_bit   = 4'd0;
    Fault_value = 1'b0;

    // Alternating write/read sweep over 1024 aliased addresses.
    do_reset();
    for (int a = 0; a < 1024; a++) begin
      issue(1'b1, 18'(a), 16'(a + 1));
      issue(1'b0, 18'(a), 16'h0);
    end
    issue(1'b0, 18'd1023, 16'h0);
    issue(1'b0, 18'd1023, 16'h0);
    check("sweep_last", 32'(SRAM_read_data), 32'h0400);
    check("sweep_wcount", 32'(Write_count), 32'd1024);
    check("sweep_rcount", 32'(Read_count), 32'd1024);
    check("sweep_uninit", 32'(Uninit_read), 32'h0);

    // Saturation of the write counter.
    @(negedge Clock);
    #1;
    force dut.write_count_q = 18'h3FFFF;
    preload = 1'b1;
    issue(1'b0, 18'd1, 16'h0);
    preload = 1'b0;
    issue(1'b0, 18'd1, 16'h0);
    release dut.write_count_q;
    issue(1'b1, 18'd20, 16'h1111);
    issue(1'b1, 18'd21, 16'h2222);
    issue(1'b1, 18'd22, 16'h3333);
    issue(1'b0, 18'd20, 16'h0);
    issue(1'b0, 18'd20, 16'h0);
    check("wcount_sat", 32'(Write_count), 32'h3FFFF);

    // Reset while a write sits in stage 1 discards it.
    do_reset();
    issue(1'b1, 18'd9, 16'h1234);
    Resetn = 1'b0;
    @(posedge Clock);
    #2;
    Resetn = 1'b1;
    issue(1'b0, 18'd9, 16'h0);
    issue(1'b0, 18'd9, 16'h0);
    issue(1'b0, 18'd9, 16'h0);
    check("inflight_uninit", 32'(Uninit_read), 32'h1);
    check("inflight_wcount", 32'(Write_count), 32'h0);
    total++;
    if (SRAM_read_data === 16'h1234) begin
      bad++;
      $display("FAIL inflight_data: got %h required anything but 1234", SRAM_read_data);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
